// File: rtl/chnl_pkg.sv
// Constants shared by the Riffa channel endpoints (chnl_rx / chnl_tx).
package chnl_pkg;

  localparam int RIFFA_WORD_W = 32;

  localparam logic [30:0] CHNL_TX_OFF_DEF  = 31'd0;
  localparam logic        CHNL_TX_LAST_DEF = 1'b1;

endpackage

// File: rtl/chnl_tx_repacker.sv
// Width converter: IN chunks of W bits in, OUT chunks out, lowest chunk first.
// The output is taken straight from the holding register, so it stays put while stalled.
module repacker #(
  parameter int IN  = 1,
  parameter int OUT = 2,
  parameter int W   = 32
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [IN*W-1:0]    in_data,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [OUT*W-1:0]   out_data
);

  localparam int CAP = IN + OUT;
  localparam int CW  = $clog2(CAP + 1);

  logic [CAP*W-1:0] buf_q, buf_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt, base;
  logic             push, pop;

  // Readiness depends only on stored occupancy; gated so it reads 0 in reset.
  assign in_rdy   = rst_ni && (cnt_q <= CW'(CAP - IN));
  assign out_val  = (cnt_q >= CW'(OUT));
  assign out_data = buf_q[OUT*W-1:0];

  always_comb begin
    push    = in_val && in_rdy;
    pop     = out_val && out_rdy;
    buf_nxt = pop ? (buf_q >> (OUT*W)) : buf_q;
    base    = pop ? (cnt_q - CW'(OUT)) : cnt_q;
    cnt_nxt = base + (push ? CW'(IN) : '0);
    if (push) begin
      for (int k = 0; k < CAP; k++) begin
        if (k >= int'(base) && k < int'(base) + IN)
          buf_nxt[k*W +: W] = in_data[(k - int'(base))*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/chnl_tx.sv
// Unbuffered Riffa TX channel: repacks the input stream to PCIe-width beats and
// sends them as fixed TX_LEN-word transactions (request, ack, then BEATS beats).
module chnl_tx
  import chnl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int TX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int TX_LEN           = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_val,
  output logic                        i_rdy,
  input  logic [TX_WIDTH-1:0]         i_data,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);

  localparam int BEATS = TX_LEN * RIFFA_WORD_W / C_PCI_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

  state_t                      state_q, state_nxt;
  logic [CNT_W-1:0]            cnt_q, cnt_nxt;
  logic                        rp_val, rp_rdy, beat;
  logic [C_PCI_DATA_WIDTH-1:0] rp_data;

  repacker #(
    .IN  (TX_WIDTH / GCD),
    .OUT (C_PCI_DATA_WIDTH / GCD),
    .W   (GCD)
  ) u_repacker (
    .clk      (clk),
    .rst_ni   (rst_n),
    .in_val   (i_val),
    .in_rdy   (i_rdy),
    .in_data  (i_data),
    .out_val  (rp_val),
    .out_rdy  (rp_rdy),
    .out_data (rp_data)
  );

  assign CHNL_TX_CLK  = clk;
  assign CHNL_TX_LAST = CHNL_TX_LAST_DEF;
  assign CHNL_TX_LEN  = 32'(TX_LEN);
  assign CHNL_TX_OFF  = CHNL_TX_OFF_DEF;
  assign CHNL_TX_DATA = rp_data;

  always_comb begin
    state_nxt          = state_q;
    cnt_nxt            = cnt_q;
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    rp_rdy             = 1'b0;
    beat               = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rp_val) state_nxt = S_REQ;
      end
      S_REQ: begin
        CHNL_TX = 1'b1;
        if (CHNL_TX_ACK) begin
          state_nxt = S_SEND;
          cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_DATA_VALID = rp_val;
        rp_rdy             = CHNL_TX_DATA_REN;
        beat               = rp_val && CHNL_TX_DATA_REN;
        if (beat) begin
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

endmodule
